cue_driver: RTL
===============

Name: cue_driver

Overview:
- Output-side counterpart to the button input path: converts a game-logic cue request into a timed drive on one of N indicator outputs (LED/buzzer enable).
- Fixed blanking gap after each cue; `cue_done` pulses when the cue finishes.
- Sits between the game FSM and the board output pins; the debounced button path is the return direction.

Parameters:
- TICK_CYCLES, 100000, clk cycles per 1 ms timebase tick (100 MHz clock).
- N_OUT, 4, number of indicator outputs.
- SEL_W, 2, width of output select; must satisfy 2**SEL_W >= N_OUT.
- DUR_W, 10, width of cue duration in ms (max 1023 ms).
- GAP_MS, 50, blank time in ms after each cue; 0 allowed.
- BLINK_MS, 100, blink half-period in ms (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cue_valid  in  1  cue request present
- cue_ready  out  1  block can accept a cue
- cue_sel  in  SEL_W  index of output to drive
- cue_dur_ms  in  DUR_W  on-time in ms
- cue_abort  in  1  cancel the current cue
- out_drv  out  N_OUT  registered output drives, one-hot or zero
- busy  out  1  high in ON or GAP
- cue_done  out  1  one-cycle pulse at cue completion

Behaviour:
- Interface: one clock (`clk`); reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, out_drv=0, busy=0, cue_done=0, all counters 0. Asserting rst clears outputs immediately, without a clock edge, including mid-cue.
- States: IDLE, ON, GAP.
- cue_ready = (state==IDLE) && !cue_abort.
- Accept: cue_valid && cue_ready at a clk edge.
  - Latches sel and dur.
  - Clears the tick counter and ms counter.
  - Next state is ON if dur!=0; otherwise GAP, or IDLE with cue_done if GAP_MS==0.
- ON:
  - out_drv[sel]=1 from the cycle after accept, for exactly dur*TICK_CYCLES cycles.
  - The tick counter wraps at TICK_CYCLES-1; the ms counter increments on each wrap.
  - When ms count reaches dur: counters clear and state goes to GAP, or to IDLE if GAP_MS==0.
- GAP: out_drv=0 for exactly GAP_MS*TICK_CYCLES cycles, then IDLE.
- cue_done: high for exactly one cycle, the first IDLE cycle after a completed cue. cue_ready is also high that cycle, so back-to-back cues are allowed.
- Out-of-range select (sel>=N_OUT): out_drv stays 0, timing runs normally, cue_done still pulses.
- cue_abort in ON or GAP:
  - Next cycle: state=IDLE, out_drv=0, counters cleared.
  - No cue_done pulse.
- cue_abort in IDLE: blocks acceptance that cycle; otherwise no effect.
- cue_valid while busy: ignored. The requester must hold valid; the cue is accepted when ready returns.
- Counter widths:
  - tick counter: clog2(TICK_CYCLES) bits.
  - ms counter: DUR_W bits, wide enough for max(dur, GAP_MS). GAP_MS must be < 2**DUR_W.
- out_drv and cue_done are registered; no combinational input-to-output paths except cue_ready from cue_abort.

Optional Feature:
- Macro: CUE_DRIVER_BLINK_EN.
- Defined: during ON, out_drv[sel] starts at 1 and toggles every BLINK_MS ms, using a separate ms counter cleared on accept. Total ON length is unchanged; the output is forced to 0 on leaving ON.
- Undefined: steady drive during ON; no blink counter logic is synthesized.

Decomposition:
- Shared package `bopit_pkg`:
  - state enum {IDLE, ON, GAP}.
  - Constants CLK_HZ and MS_TICKS (=CLK_HZ/1000), shared with the debouncer's DELAY.
- One natural sub-module: `ms_timebase`, a clearable TICK_CYCLES divider emitting a one-cycle tick. Reusable for the debounce delay and game timers.

Test Plan:
- All tests use TICK_CYCLES=4, GAP_MS=2, N_OUT=4 unless noted.
- Reset: assert rst mid-clock -> out_drv=0, busy=0, cue_done=0 immediately; cue_ready=1 after release.
- Cue sel=2, dur=3 -> out_drv=4'b0100 for exactly 12 cycles starting the cycle after accept, then 8 cycles of 0, then cue_done=1 for one cycle with cue_ready=1.
- Cue dur=0, sel=1 -> out_drv never nonzero; cue_done after 8 GAP cycles. With GAP_MS=0 -> cue_done the cycle after accept.
- cue_valid held high with sel=0 dur=1, then sel=3 dur=1 -> second cue accepted on the cue_done cycle; out_drv=0001 for 4 cycles, gap 8, then 1000 for 4 cycles.
- cue_abort on the 5th ON cycle of dur=3 -> out_drv=0 and state IDLE next cycle, no cue_done. cue_valid+cue_abort together in IDLE -> not accepted.
- CUE_DRIVER_BLINK_EN with BLINK_MS=1, sel=0, dur=4 -> out_drv[0] pattern 1111 0000 1111 0000 across 16 cycles, then 0.

Source files
------------

// File: rtl/bopit_pkg.sv
// Shared definitions for the bop-it board: clock/timebase constants and the
// cue driver state encoding.
package bopit_pkg;

  localparam int CLK_HZ   = 100_000_000;
  localparam int MS_TICKS = CLK_HZ / 1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } cue_state_e;

endpackage

// File: rtl/ms_timebase.sv
// Clearable TICK_CYCLES divider; tick_o is a one-cycle pulse on the last
// cycle of each period while enabled.
module ms_timebase import bopit_pkg::*; #(
  parameter int TICK_CYCLES = MS_TICKS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cue_driver.sv
// Timed indicator driver: turns a cue request into an on-time drive on one
// output followed by a blanking gap. Optional blink mode: CUE_DRIVER_BLINK_EN.
//
// state | meaning
// IDLE  | ready for a cue; cue_done may pulse here
// ON    | driving out_drv[sel] for dur ms
// GAP   | outputs blank for GAP_MS ms
module cue_driver import bopit_pkg::*; #(
  parameter int TICK_CYCLES = MS_TICKS,
  parameter int N_OUT       = 4,
  parameter int SEL_W       = 2,
  parameter int DUR_W       = 10,
  parameter int GAP_MS      = 50,
  parameter int BLINK_MS    = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cue_valid,
  output logic             cue_ready,
  input  logic [SEL_W-1:0] cue_sel,
  input  logic [DUR_W-1:0] cue_dur_ms,
  input  logic             cue_abort,
  output logic [N_OUT-1:0] out_drv,
  output logic             busy,
  output logic             cue_done
);

  localparam logic [DUR_W-1:0] MS_ONE   = DUR_W'(1);
  localparam logic [DUR_W-1:0] GAP_LAST = (GAP_MS > 0) ? DUR_W'(GAP_MS - 1) : '0;

  cue_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [DUR_W-1:0] ms_q, ms_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             accept, tick, tb_clr, drive_en;

  function automatic logic [N_OUT-1:0] sel_onehot(input logic [SEL_W-1:0] s);
    logic [N_OUT-1:0] v;
    v = '0;
    // Selects at or beyond N_OUT match nothing and leave the drive at zero.
    for (int i = 0; i < N_OUT; i++) begin
      if (s == SEL_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  assign cue_ready = (state_q == IDLE) && !cue_abort;
  assign accept    = cue_valid && cue_ready;
  assign busy      = (state_q != IDLE);
  assign out_drv   = out_q;
  assign cue_done  = done_q;
  assign tb_clr    = accept || (state_d != state_q);

  ms_timebase #(.TICK_CYCLES(TICK_CYCLES)) u_ms_timebase (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (tb_clr),
    .en_i   (busy),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dur_d   = dur_q;
    ms_d    = ms_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d = cue_sel;
          dur_d = cue_dur_ms;
          ms_d  = '0;
          if (cue_dur_ms != '0)  state_d = ON;
          else if (GAP_MS != 0)  state_d = GAP;
          else                   done_d  = 1'b1;
        end
      end
      ON: begin
        if (cue_abort) begin
          state_d = IDLE;
          ms_d    = '0;
        end else if (tick) begin
          if (ms_q + MS_ONE == dur_q) begin
            ms_d = '0;
            if (GAP_MS != 0) begin
              state_d = GAP;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            ms_d = ms_q + MS_ONE;
          end
        end
      end
      GAP: begin
        if (cue_abort) begin
          state_d = IDLE;
          ms_d    = '0;
        end else if (tick) begin
          if (ms_q == GAP_LAST) begin
            state_d = IDLE;
            ms_d    = '0;
            done_d  = 1'b1;
          end else begin
            ms_d = ms_q + MS_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        ms_d    = '0;
      end
    endcase
    out_d = (state_d == ON && drive_en) ? sel_onehot(sel_d) : '0;
  end

`ifdef CUE_DRIVER_BLINK_EN
  localparam logic [DUR_W-1:0] BLINK_LAST = DUR_W'(BLINK_MS - 1);

  logic [DUR_W-1:0] blink_q, blink_d;
  logic             phase_q, phase_d;

  // Phase is evaluated for the next cycle so the toggle lands right after a tick.
  always_comb begin
    blink_d = blink_q;
    phase_d = phase_q;
    if (accept) begin
      blink_d = '0;
      phase_d = 1'b1;
    end else if (state_q == ON && tick) begin
      if (blink_q == BLINK_LAST) begin
        blink_d = '0;
        phase_d = !phase_q;
      end else begin
        blink_d = blink_q + MS_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_q <= '0;
      phase_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
  end

  assign drive_en = phase_d;
`else
  assign drive_en = 1'b1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      dur_q   <= '0;
      ms_q    <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dur_q   <= dur_d;
      ms_q    <= ms_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

endmodule
